step_phase_monitor: RTL and testbench
=====================================

STEP_PHASE_MONITOR -- requirements
Module: step_phase_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive clk cycles a synchronized phase code must hold before acceptance (range 1..255).
REQ-002 SHALL have parameter STROKE_STEPS, default 100, meaning step count (0.9 deg each) that defines a full cut stroke.
REQ-003 SHALL have one clock and synchronous active-high reset: clk input 1, system clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have phase_i input 4, observed motor coil code {B',A',B,A}.
REQ-005 SHALL have clr_i input 1, synchronous clear of position, error and stroke tracking.
REQ-006 SHALL have step_valid_o output 1, one-cycle pulse per accepted legal step.
REQ-007 SHALL have dir_o output 1, direction of the last accepted step: 1 = forward, 0 = reverse.
REQ-008 SHALL have pos_o output 9, signed step position.
REQ-009 SHALL have stroke_done_o output 1, one-cycle pulse on completed stroke.
REQ-010 SHALL have err_o output 1, sticky protocol error.
REQ-011 SHALL have idle_o output 1, high while the accepted phase is 0000.

Function
REQ-012 SHALL pass phase_i through a two-flop synchronizer, then a stability counter; a code is accepted when unchanged for STABLE_CYCLES consecutive synchronized samples.
REQ-013 SHALL pulse step_valid_o exactly STABLE_CYCLES+2 cycles after the first clk edge sampling a new stable phase_i value; glitches shorter than STABLE_CYCLES SHALL produce no output change.
REQ-014 SHALL treat 0011, 0110, 1100, 1001 as legal codes and 0000 as idle; all other codes are illegal.
REQ-015 SHALL decode forward as 0011->0110->1100->1001->0011 and reverse as the opposite order.
REQ-016 SHALL implement FSM states IDLE, TRACK, ERROR.
REQ-017 In IDLE, SHALL move to TRACK on acceptance of any legal code, with no step counted and pos_o unchanged.
REQ-018 In TRACK, a forward step SHALL increment pos_o and set dir_o=1; a reverse step SHALL decrement pos_o and set dir_o=0; both SHALL pulse step_valid_o.
REQ-019 In TRACK, acceptance of 0000 SHALL return to IDLE with pos_o retained.
REQ-020 In IDLE or TRACK, acceptance of an illegal code, or a legal code two positions away (e.g. 0011->1100), SHALL enter ERROR, set err_o, and leave pos_o unchanged.
REQ-021 SHALL leave ERROR only on clr_i or rst, going to IDLE; steps are ignored while in ERROR.
REQ-022 SHALL saturate pos_o at +255 and -256, with no wrap-around; step_valid_o still pulses at saturation.
REQ-023 SHALL set an internal reached flag when |pos_o| >= STROKE_STEPS.
REQ-024 SHALL pulse stroke_done_o for the step that brings pos_o to 0 while reached is set, then clear reached.
REQ-025 clr_i SHALL zero pos_o, clear err_o and reached, and enter IDLE; if clr_i coincides with a step acceptance, clr_i SHALL win, no step_valid_o SHALL be produced, and the next accepted code SHALL be treated as the IDLE entry code.

Reset
REQ-026 On rst, SHALL set state to IDLE, clear synchronizer flops, stability counter and reached, and set pos_o=0, dir_o=0, step_valid_o=0, stroke_done_o=0, err_o=0, idle_o=1.
REQ-027 Reset asserted mid-stroke SHALL discard all tracking, with no stroke_done_o after release until a new full stroke completes.

Structure
REQ-028 SHALL place the phase code constants (PH_IDLE, PH_1..PH_4) and the FSM state encoding in shared package step_pkg, reused by the motor drivers.
REQ-029 SHALL implement synchronizer plus stability filter as sub-module phase_filter, with outputs accepted code and one-cycle accept strobe.

Verification
REQ-030 Bench SHALL cover: idle then 0011 held 10 cycles, then 0110, 1100, 1001, 0011, each held 10 cycles -> 4 step_valid_o pulses, dir_o=1, pos_o=4.
REQ-031 Bench SHALL cover: forward 100 steps then reverse 100 steps -> pos_o peaks at 100, a single stroke_done_o pulse coincides with pos_o=0.
REQ-032 Bench SHALL cover: in TRACK at 0011, apply 0110 for 2 cycles then back to 0011 (STABLE_CYCLES=4) -> no step_valid_o, pos_o unchanged.
REQ-033 Bench SHALL cover: in TRACK at 0011, apply 1100 held -> err_o=1, later steps ignored; after clr_i -> err_o=0, pos_o=0, state IDLE.
REQ-034 Bench SHALL cover: 300 forward steps -> pos_o saturates at 255 with pulses continuing; clr_i asserted on the same cycle as a step accept -> pos_o=0, no step_valid_o.
REQ-035 Bench SHALL cover: rst pulsed at pos_o=60 -> all outputs at reset values, idle_o=1, and no stroke_done_o on the subsequent return to 0 without reaching 100.

Source files
------------

// File: rtl/step_pkg.sv
// Phase codes and FSM encoding for the stepper coil-monitoring and drive blocks.
// The decode helper maps a legal coil code onto its position in the forward cycle.
package step_pkg;

    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH_1    = 4'b0011;
    localparam logic [3:0] PH_2    = 4'b0110;
    localparam logic [3:0] PH_3    = 4'b1100;
    localparam logic [3:0] PH_4    = 4'b1001;

    localparam logic signed [8:0] POS_MAX = 9'sh0ff;
    localparam logic signed [8:0] POS_MIN = 9'sh100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } phase_dec_t;

    function automatic phase_dec_t phase_decode(input logic [3:0] code);
        phase_dec_t d;
        d.legal = 1'b1;
        d.idx   = 2'd0;
        case (code)
            PH_1:    d.idx = 2'd0;
            PH_2:    d.idx = 2'd1;
            PH_3:    d.idx = 2'd2;
            PH_4:    d.idx = 2'd3;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchronizer plus stability filter: strobes accept_o once when a new
// code has been held for STABLE_CYCLES consecutive synchronized samples.
module phase_filter
    import step_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    output logic [3:0] code_o,
    output logic       accept_o
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       accept_q, accept_d;
    logic       counting;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        accept_d = 1'b0;
        counting = (sync2_q != cand_q) || (cnt_q != STABLE_CNT);

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd1;
        end else if (cnt_q != STABLE_CNT) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A glitch that returns to the already accepted code must not re-strobe.
        if (counting && cnt_d == STABLE_CNT && cand_d != code_q) begin
            code_d   = cand_d;
            accept_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= PH_IDLE;
            sync2_q  <= PH_IDLE;
            cand_q   <= PH_IDLE;
            cnt_q    <= '0;
            code_q   <= PH_IDLE;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= phase_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            accept_q <= accept_d;
        end
    end

    assign code_o   = code_q;
    assign accept_o = accept_q;

endmodule

// File: rtl/step_phase_monitor.sv
// Stepper coil-phase monitor: tracks signed step position from filtered coil codes,
// flags protocol errors and pulses when a full cut stroke returns to zero.
module step_phase_monitor
    import step_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned STROKE_STEPS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    input  logic       clr_i,
    output logic       step_valid_o,
    output logic       dir_o,
    output logic [8:0] pos_o,
    output logic       stroke_done_o,
    output logic       err_o,
    output logic       idle_o
);

    logic [3:0] acc_code;
    logic       acc_stb;

    phase_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .phase_i  (phase_i),
        .code_o   (acc_code),
        .accept_o (acc_stb)
    );

    state_t            state_q, state_d;
    logic [1:0]        cur_q, cur_d;
    logic signed [8:0] pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              step_valid_q, step_valid_d;
    logic              stroke_done_q, stroke_done_d;
    logic              err_q, err_d;
    logic              reached_q, reached_d;

    phase_dec_t dec;
    logic [1:0] delta;
    logic       step_fwd, step_rev;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        pos_d         = pos_q;
        dir_d         = dir_q;
        step_valid_d  = 1'b0;
        stroke_done_d = 1'b0;
        err_d         = err_q;
        reached_d     = reached_q;
        step_fwd      = 1'b0;
        step_rev      = 1'b0;
        dec           = phase_decode(acc_code);
        delta         = dec.idx - cur_q;

        if (clr_i) begin
            state_d   = ST_IDLE;
            pos_d     = '0;
            err_d     = 1'b0;
            reached_d = 1'b0;
        end else if (acc_stb) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dec.legal) begin
                        state_d = ST_TRACK;
                        cur_d   = dec.idx;
                    end else if (acc_code != PH_IDLE) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (acc_code == PH_IDLE) begin
                        state_d = ST_IDLE;
                    end else if (!dec.legal || delta == 2'd2) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        cur_d    = dec.idx;
                        step_fwd = (delta == 2'd1);
                        step_rev = (delta == 2'd3);
                    end
                end
                default: ;
            endcase
        end

        if (step_fwd || step_rev) begin
            step_valid_d = 1'b1;
            dir_d        = step_fwd;
            if (step_fwd && pos_q != POS_MAX) pos_d = pos_q + 9'sd1;
            if (step_rev && pos_q != POS_MIN) pos_d = pos_q - 9'sd1;
            // A stroke completes on the step that lands on zero after reaching full travel.
            if (pos_d == 9'sd0 && reached_q) begin
                stroke_done_d = 1'b1;
                reached_d     = 1'b0;
            end else if (int'(pos_d) >= int'(STROKE_STEPS) ||
                         int'(pos_d) <= -int'(STROKE_STEPS)) begin
                reached_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_q         <= 2'd0;
            pos_q         <= '0;
            dir_q         <= 1'b0;
            step_valid_q  <= 1'b0;
            stroke_done_q <= 1'b0;
            err_q         <= 1'b0;
            reached_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            step_valid_q  <= step_valid_d;
            stroke_done_q <= stroke_done_d;
            err_q         <= err_d;
            reached_q     <= reached_d;
        end
    end

    assign step_valid_o  = step_valid_q;
    assign dir_o         = dir_q;
    assign pos_o         = pos_q;
    assign stroke_done_o = stroke_done_q;
    assign err_o         = err_q;
    assign idle_o        = (acc_code == PH_IDLE);

endmodule

// File: tb/tb_step_phase_monitor.sv
// Self-checking bench for step_phase_monitor: directed scenarios plus random coil
// sequences, checked against a step-level behavioural model of the monitor.
module tb_step_phase_monitor;

    localparam int S      = 4;
    localparam int STROKE = 100;
    localparam int HOLD   = S + 6;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_ERROR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] phase_i;
    logic       clr_i;
    logic       step_valid_o, dir_o, stroke_done_o, err_o, idle_o;
    logic [8:0] pos_o;

    always #5 clk = ~clk;

    step_phase_monitor #(
        .STABLE_CYCLES (S),
        .STROKE_STEPS  (STROKE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .phase_i       (phase_i),
        .clr_i         (clr_i),
        .step_valid_o  (step_valid_o),
        .dir_o         (dir_o),
        .pos_o         (pos_o),
        .stroke_done_o (stroke_done_o),
        .err_o         (err_o),
        .idle_o        (idle_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int tot_steps, tot_strokes, peak, saved;

    // Behavioural model: abstract monitor state at step granularity.
    int         m_mode, m_idx, m_pos;
    bit         m_dir, m_err, m_reached;
    logic [3:0] m_last;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code_index(input logic [3:0] c);
        case (c)
            4'b0011: return 0;
            4'b0110: return 1;
            4'b1100: return 2;
            4'b1001: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] code_at(input int i);
        case (i % 4)
            0:       return 4'b0011;
            1:       return 4'b0110;
            2:       return 4'b1100;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_pos = 0;
        m_dir = 0; m_err = 0; m_reached = 0; m_last = 4'b0000;
    endtask

    task automatic model_clr();
        m_mode = M_IDLE; m_pos = 0; m_err = 0; m_reached = 0;
    endtask

    task automatic model_accept(input logic [3:0] code, output int st, output int sd);
        int i, d;
        st = 0; sd = 0;
        m_last = code;
        i = code_index(code);
        if (m_mode == M_IDLE) begin
            if (i >= 0) begin m_mode = M_TRACK; m_idx = i; end
            else if (code != 4'b0000) begin m_mode = M_ERROR; m_err = 1; end
        end else if (m_mode == M_TRACK) begin
            if (code == 4'b0000) m_mode = M_IDLE;
            else if (i < 0) begin m_mode = M_ERROR; m_err = 1; end
            else begin
                d = (i - m_idx + 4) % 4;
                if (d == 2) begin m_mode = M_ERROR; m_err = 1; end
                else if (d != 0) begin
                    m_idx = i;
                    st = 1;
                    if (d == 1) begin m_dir = 1; m_pos = (m_pos < 255) ? m_pos + 1 : 255; end
                    else begin m_dir = 0; m_pos = (m_pos > -256) ? m_pos - 1 : -256; end
                    if (m_reached && m_pos == 0) begin sd = 1; m_reached = 0; end
                    else if (m_pos >= STROKE || m_pos <= -STROKE) m_reached = 1;
                end
            end
        end
    endtask

    // Called at a negedge; drives code for exactly `hold` synchronizer samples.
    task automatic apply(input logic [3:0] code, input int hold, input bit clr_at_acc);
        int steps, strokes, lat, exp_st, exp_sd;
        bit exp_acc;
        phase_i = code;
        exp_acc = (hold >= S) && (code != m_last);
        steps = 0; strokes = 0; lat = -1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            clr_i = (clr_at_acc && exp_acc && i == S + 1);
            if (int'($signed(pos_o)) > peak) peak = int'($signed(pos_o));
            if (step_valid_o) begin steps++; if (lat < 0) lat = i; end
            if (stroke_done_o) begin
                strokes++;
                check("stroke_at_zero", $signed(pos_o), 0);
            end
        end
        clr_i = 1'b0;
        exp_st = 0; exp_sd = 0;
        if (exp_acc) begin
            if (clr_at_acc) begin m_last = code; model_clr(); end
            else model_accept(code, exp_st, exp_sd);
        end
        tot_steps   += steps;
        tot_strokes += strokes;
        check("step_pulses", steps, exp_st);
        check("stroke_pulses", strokes, exp_sd);
        if (exp_st == 1) check("step_latency", lat, S + 2);
        check("pos", $signed(pos_o), m_pos);
        check("dir", dir_o, m_dir);
        check("err", err_o, m_err);
        check("idle", idle_o, m_last == 4'b0000);
    endtask

    task automatic step_fwd(input int n);
        repeat (n) apply(code_at(code_index(m_last) + 1), HOLD, 0);
    endtask

    task automatic step_rev(input int n);
        repeat (n) apply(code_at(code_index(m_last) + 3), HOLD, 0);
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        model_clr();
        check("clr_pos", $signed(pos_o), 0);
        check("clr_err", err_o, 0);
    endtask

    task automatic check_reset_values();
        check("rst_step_valid", step_valid_o, 0);
        check("rst_dir", dir_o, 0);
        check("rst_pos", $signed(pos_o), 0);
        check("rst_stroke", stroke_done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_idle", idle_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr_i = 1'b0; phase_i = 4'b0000; peak = -1000;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Entry plus four forward steps.
        tot_steps = 0;
        apply(4'b0011, HOLD, 0);
        apply(4'b0110, HOLD, 0);
        apply(4'b1100, HOLD, 0);
        apply(4'b1001, HOLD, 0);
        apply(4'b0011, HOLD, 0);
        check("fwd4_pulses", tot_steps, 4);
        check("fwd4_pos", $signed(pos_o), 4);
        check("fwd4_dir", dir_o, 1);

        // Short glitch to the next code and back produces nothing.
        apply(4'b0110, 2, 0);
        apply(4'b0011, HOLD, 0);
        check("glitch_pos", $signed(pos_o), 4);

        // Full stroke out and back.
        do_clr();
        apply(4'b0110, HOLD, 0);
        peak = -1000; tot_strokes = 0;
        step_fwd(100);
        step_rev(100);
        check("stroke_peak", peak, 100);
        check("stroke_count", tot_strokes, 1);
        check("stroke_end_pos", $signed(pos_o), 0);

        // Skip of two positions enters ERROR; steps ignored until clear.
        while (m_last != 4'b0011) step_fwd(1);
        saved = m_pos;
        apply(4'b1100, HOLD, 0);
        check("skip_err", err_o, 1);
        step_fwd(2);
        check("err_hold_pos", $signed(pos_o), saved);
        do_clr();
        tot_steps = 0;
        step_fwd(2);
        check("after_clr_steps", tot_steps, 1);

        // Saturation, then clear landing on an accept.
        do_clr();
        step_fwd(1);
        tot_steps = 0;
        step_fwd(300);
        check("sat_pos", $signed(pos_o), 255);
        check("sat_pulses", tot_steps, 300);
        tot_steps = 0;
        apply(code_at(code_index(m_last) + 1), HOLD, 1);
        check("clr_acc_pos", $signed(pos_o), 0);
        step_fwd(2);
        check("clr_acc_steps", tot_steps, 1);

        // Reset mid-stroke discards tracking.
        do_clr();
        step_fwd(1);
        step_fwd(60);
        check("pre_rst_pos", $signed(pos_o), 60);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        model_reset();
        rst = 1'b0;
        apply(phase_i, HOLD, 0);
        tot_strokes = 0;
        step_fwd(30);
        step_rev(30);
        check("post_rst_strokes", tot_strokes, 0);

        // Random coil activity.
        for (int k = 0; k < 80; k++) begin
            int op, ci;
            op = $urandom_range(0, 9);
            ci = code_index(m_last);
            if (op == 0) do_clr();
            else if (op == 1) apply(4'($urandom_range(0, 15)), $urandom_range(S + 3, S + 6), 0);
            else if (op == 2) begin
                apply(4'($urandom_range(0, 15)), $urandom_range(1, S - 1), 0);
                apply(m_last, HOLD, 0);
            end
            else if (ci < 0) apply(code_at($urandom_range(0, 3)), HOLD, 0);
            else apply(code_at(ci + (($urandom_range(0, 1) == 1) ? 1 : 3)),
                       $urandom_range(S + 3, S + 6), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
